seq_alu: RTL and testbench

- Parametrised, clocked ALU with valid/ready handshakes on both sides; the next generation of the 16-bit combinational ALU.
- Adds variable-distance shifts and rotate, an iterative shift-add multiplier, an internal accumulator, and Zero/Negative flags.
- Sits between an operand-issue stage and a result consumer; one operation in flight at a time.

---
 rtl/seq_alu_pkg.sv | 34 +++
 rtl/seq_alu_if.sv | 32 +++
 rtl/cla_adder_n.sv | 40 ++++
 rtl/seq_alu.sv | 250 +++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: operation codes and FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seq_alu_pkg;

  // Operation select codes carried on the mode field
  localparam logic [3:0] MODE_SLL   = 4'd0;
  localparam logic [3:0] MODE_SRL   = 4'd1;
  localparam logic [3:0] MODE_SRA   = 4'd2;
  localparam logic [3:0] MODE_ROL   = 4'd3;
  localparam logic [3:0] MODE_ADD   = 4'd4;
  localparam logic [3:0] MODE_SUB   = 4'd5;
  localparam logic [3:0] MODE_AND   = 4'd6;
  localparam logic [3:0] MODE_OR    = 4'd7;
  localparam logic [3:0] MODE_XOR   = 4'd8;
  localparam logic [3:0] MODE_NOR   = 4'd9;
  localparam logic [3:0] MODE_SLT   = 4'd10;
  localparam logic [3:0] MODE_SLTU  = 4'd11;
  localparam logic [3:0] MODE_MUL   = 4'd12;
  localparam logic [3:0] MODE_CLZ   = 4'd13;
  localparam logic [3:0] MODE_LDACC = 4'd14;
  localparam logic [3:0] MODE_ACC   = 4'd15;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Shift/rotate modes occupy codes 0..3 and iterate one bit per cycle
  function automatic logic is_shift(input logic [3:0] m);
    return (m[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the operand-issue stage, the ALU and the result consumer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: request = in_valid, in_ready, a, b, cin, mode; result = out_valid, out_ready, y,
//        cout, overflow, zero, negative. master = issuer/consumer side, slave = ALU side.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [3:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, y, cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, y, cout, overflow, zero, negative
  );
endinterface

// File: rtl/cla_adder_n.sv
// WIDTH-bit adder: 4-bit carry-lookahead groups, group carries rippled between groups.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y operands; cin carry in; s sum; cout carry out of the top bit.
module cla_adder_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG:0]      gc;

  assign g     = x & y;
  assign p     = x ^ y;
  assign gc[0] = cin;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    localparam int B = 4 * i;
    // Carries inside the group are all computed directly from the group carry-in
    assign c[B]   = gc[i];
    assign c[B+1] = g[B] | (p[B] & gc[i]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[i]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[i]);
    assign gc[i+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                   | (p[B+3] & p[B+2] & p[B+1] & g[B])
                   | (p[B+3] & p[B+2] & p[B+1] & p[B] & gc[i]);
  end

  assign s    = p ^ c;
  assign cout = gc[NG];
endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with shifts/rotate, iterative shift-add multiplier, accumulator and Z/N flags.
// Latency: 1 cycle single-cycle ops, k+1 for shift/rotate by k, WIDTH+1 for MUL.
// Backpressure: result held in DONE until out_ready; a new request may be taken in the handshake cycle.
// Ports: clk, rst_n (async active-low); bus (slave modport of seq_alu_if) carries
//        request a/b/cin/mode with in_valid/in_ready and result y/cout/overflow/zero/negative
//        with out_valid/out_ready.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int SW  = $clog2(WIDTH);
  localparam int CW  = SW + 1;
  localparam int MSB = WIDTH - 1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] w_q, w_d;     // shift value, or multiplier / product low half
  logic [WIDTH-1:0] hi_q, hi_d;   // product high half
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic             in_ready;
  logic             accept;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] add_x, add_y, add_s;
  logic             add_ci, add_co;
  logic [CW-1:0]    clz;
  logic [WIDTH-1:0] step_w, step_hi;
  logic             res_wr;
  logic [WIDTH-1:0] res_y;
  logic             res_cout, res_ovf;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign shamt    = bus.b[SW-1:0];

  // One adder serves the multiplier partial sum while BUSY and ADD/SUB/ACC at accept;
  // the two never coincide because nothing is accepted while BUSY.
  always_comb begin
    add_x  = bus.a;
    add_y  = bus.b;
    add_ci = bus.cin;
    if (state_q == ST_BUSY) begin
      add_x  = hi_q;
      add_y  = a_q;
      add_ci = 1'b0;
    end else begin
      case (bus.mode)
        MODE_SUB: begin
          add_y  = ~bus.b;
          add_ci = 1'b1;
        end
        MODE_ACC: begin
          add_x  = acc_q;
          add_y  = bus.a;
          add_ci = 1'b0;
        end
        default: ;
      endcase
    end
  end

  cla_adder_n #(.WIDTH(WIDTH)) u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_ci),
    .s    (add_s),
    .cout (add_co)
  );

  // Leading-zero count; all-zero input falls through to WIDTH
  always_comb begin
    logic found;
    clz   = CW'(WIDTH);
    found = 1'b0;
    for (int i = MSB; i >= 0; i--) begin
      if (!found && bus.a[i]) begin
        clz   = CW'(MSB - i);
        found = 1'b1;
      end
    end
  end

  // One BUSY iteration: a 1-bit shift/rotate, or one shift-add multiply step
  // where {carry, hi + a} (or plain hi) and the multiplier shift right together.
  always_comb begin
    step_w  = w_q;
    step_hi = hi_q;
    case (mode_q)
      MODE_SLL: step_w = {w_q[MSB-1:0], 1'b0};
      MODE_SRL: step_w = {1'b0, w_q[MSB:1]};
      MODE_SRA: step_w = {w_q[MSB], w_q[MSB:1]};
      MODE_ROL: step_w = {w_q[MSB-1:0], w_q[MSB]};
      MODE_MUL: begin
        if (w_q[0]) begin
          step_hi = {add_co, add_s[MSB:1]};
          step_w  = {add_s[0], w_q[MSB:1]};
        end else begin
          step_hi = {1'b0, hi_q[MSB:1]};
          step_w  = {hi_q[0], w_q[MSB:1]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    w_d      = w_q;
    hi_d     = hi_q;
    acc_d    = acc_q;
    y_d      = y_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    res_wr   = 1'b0;
    res_y    = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;

    case (state_q)
      ST_BUSY: begin
        w_d   = step_w;
        hi_d  = step_hi;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          res_wr  = 1'b1;
          res_y   = step_w;
          res_ovf = (mode_q == MODE_MUL) && (step_hi != '0);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Operands are captured here; single-cycle results are formed from the
    // request itself so they are ready one cycle after accept.
    if (accept) begin
      mode_d = bus.mode;
      a_d    = bus.a;
      if (is_shift(bus.mode) && (shamt != '0)) begin
        state_d = ST_BUSY;
        w_d     = bus.a;
        cnt_d   = CW'(shamt);
      end else if (bus.mode == MODE_MUL) begin
        state_d = ST_BUSY;
        w_d     = bus.b;
        hi_d    = '0;
        cnt_d   = CW'(WIDTH);
      end else begin
        state_d = ST_DONE;
        res_wr  = 1'b1;
        case (bus.mode)
          MODE_ADD: begin
            res_y    = add_s;
            res_cout = add_co;
            res_ovf  = (bus.a[MSB] == bus.b[MSB]) && (add_s[MSB] != bus.a[MSB]);
          end
          MODE_SUB: begin
            res_y    = add_s;
            res_cout = add_co;
            res_ovf  = (bus.a[MSB] != bus.b[MSB]) && (add_s[MSB] != bus.a[MSB]);
          end
          MODE_AND:  res_y = bus.a & bus.b;
          MODE_OR:   res_y = bus.a | bus.b;
          MODE_XOR:  res_y = bus.a ^ bus.b;
          MODE_NOR:  res_y = ~(bus.a | bus.b);
          MODE_SLT:  res_y = WIDTH'($signed(bus.a) < $signed(bus.b));
          MODE_SLTU: res_y = WIDTH'(bus.a < bus.b);
          MODE_CLZ:  res_y = WIDTH'(clz);
          MODE_LDACC: begin
            res_y = bus.a;
            acc_d = bus.a;
          end
          MODE_ACC: begin
            res_y    = add_s;
            res_cout = add_co;
            res_ovf  = (acc_q[MSB] == bus.a[MSB]) && (add_s[MSB] != acc_q[MSB]);
            acc_d    = add_s;
          end
          default: res_y = bus.a;  // shift/rotate by zero
        endcase
      end
    end

    if (res_wr) begin
      y_d    = res_y;
      cout_d = res_cout;
      ovf_d  = res_ovf;
      zero_d = (res_y == '0);
      neg_d  = res_y[MSB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      w_q     <= '0;
      hi_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      w_q     <= w_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16.
// Latency: measured per operation from the accept edge to out_valid.
// Backpressure: exercises a 10-cycle out_ready stall and a back-to-back handshake.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nerr;
  int   lat;

  seq_alu_if #(.WIDTH(16)) bus ();

  seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then measure cycles from accept to out_valid
  task automatic run_op(input string tag, input logic [3:0] m, input logic [15:0] av,
                        input logic [15:0] bv, input logic ci, input int exp_lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = ci;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    nchk          = 0;
    nerr          = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.mode      = '0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y, 16'h0000);
    check("rst_zero", bus.zero, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with signed overflow
    run_op("add_ovf", MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 1);
    check("add_y", bus.y, 16'h8000);
    check("add_ovf", bus.overflow, 1);
    check("add_cout", bus.cout, 0);
    check("add_neg", bus.negative, 1);
    consume();
    run_op("add_cin", MODE_ADD, 16'h0002, 16'h0003, 1'b1, 1);
    check("add_cin_y", bus.y, 16'h0006);
    consume();

    // SUB with borrow, then equal operands
    run_op("sub_borrow", MODE_SUB, 16'h0005, 16'h0007, 1'b0, 1);
    check("sub_y", bus.y, 16'hFFFE);
    check("sub_cout", bus.cout, 0);
    check("sub_ovf", bus.overflow, 0);
    consume();
    run_op("sub_eq", MODE_SUB, 16'h0007, 16'h0007, 1'b0, 1);
    check("sub_eq_y", bus.y, 16'h0000);
    check("sub_eq_zero", bus.zero, 1);
    check("sub_eq_cout", bus.cout, 1);
    consume();

    // Shifts and rotate
    run_op("sra4", MODE_SRA, 16'h8010, 16'h0004, 1'b0, 5);
    check("sra4_y", bus.y, 16'hF801);
    consume();
    run_op("rol1", MODE_ROL, 16'h8001, 16'h0001, 1'b0, 2);
    check("rol1_y", bus.y, 16'h0003);
    consume();
    run_op("sll0", MODE_SLL, 16'h1234, 16'h0000, 1'b0, 1);
    check("sll0_y", bus.y, 16'h1234);
    consume();
    run_op("srl3", MODE_SRL, 16'h8000, 16'h0003, 1'b0, 4);
    check("srl3_y", bus.y, 16'h1000);
    consume();

    // Multiplier
    run_op("mul300", MODE_MUL, 16'd300, 16'd300, 1'b0, 17);
    check("mul300_y", bus.y, 16'h5F90);
    check("mul300_ovf", bus.overflow, 1);
    check("mul300_cout", bus.cout, 0);
    consume();
    run_op("mul0", MODE_MUL, 16'h0000, 16'hFFFF, 1'b0, 17);
    check("mul0_y", bus.y, 16'h0000);
    check("mul0_zero", bus.zero, 1);
    check("mul0_ovf", bus.overflow, 0);
    consume();

    // Compare and leading-zero count
    run_op("slt", MODE_SLT, 16'hFFFF, 16'h0001, 1'b0, 1);
    check("slt_y", bus.y, 16'h0001);
    consume();
    run_op("sltu", MODE_SLTU, 16'hFFFF, 16'h0001, 1'b0, 1);
    check("sltu_y", bus.y, 16'h0000);
    consume();
    run_op("clz", MODE_CLZ, 16'h0010, 16'h0000, 1'b0, 1);
    check("clz_y", bus.y, 16'h000B);
    consume();
    run_op("clz0", MODE_CLZ, 16'h0000, 16'h0000, 1'b0, 1);
    check("clz0_y", bus.y, 16'h0010);
    consume();

    // Result stall: outputs hold and no new request is taken
    run_op("xor", MODE_XOR, 16'hF0F0, 16'hFF00, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      check("stall_y", bus.y, 16'h0FF0);
      check("stall_vld", bus.out_valid, 1);
      check("stall_in_rdy", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    // Handshake and new accept in the same cycle
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.mode      = MODE_AND;
    bus.a         = 16'hF0F0;
    bus.b         = 16'hFF00;
    #1;
    check("b2b_in_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_vld", bus.out_valid, 1);
    check("b2b_y", bus.y, 16'hF000);
    consume();

    // Accumulator wrap
    run_op("ldacc", MODE_LDACC, 16'hFFFF, 16'h0000, 1'b0, 1);
    check("ldacc_y", bus.y, 16'hFFFF);
    consume();
    run_op("acc", MODE_ACC, 16'h0001, 16'h0000, 1'b0, 1);
    check("acc_y", bus.y, 16'h0000);
    check("acc_cout", bus.cout, 1);
    check("acc_zero", bus.zero, 1);
    check("acc_ovf", bus.overflow, 0);
    consume();

    // Reset in the middle of a multiply
    bus.in_valid = 1'b1;
    bus.mode     = MODE_MUL;
    bus.a        = 16'd300;
    bus.b        = 16'd300;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_vld", bus.out_valid, 0);
    check("busy_in_rdy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mrst_y", bus.y, 16'h0000);
    check("mrst_cout", bus.cout, 0);
    check("mrst_zero", bus.zero, 0);
    check("mrst_in_rdy", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mrst_no_result", bus.out_valid, 0);
    run_op("acc_after_rst", MODE_ACC, 16'h0005, 16'h0000, 1'b0, 1);
    check("acc_after_rst_y", bus.y, 16'h0005);
    consume();
    run_op("or_after_rst", MODE_OR, 16'h0F00, 16'h00F0, 1'b0, 1);
    check("or_after_rst_y", bus.y, 16'h0FF0);
    consume();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
